// File: rtl/memory_access_unit.sv
// MEM-stage access unit: word RAM with byte/half lanes, branch redirect.
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning.
module memory_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Req_Valid,
    output logic                Req_Ready,
    input  logic                R_Enable,
    input  logic                W_Enable,
    input  logic [1:0]          R_Width,
    input  logic [1:0]          W_Width,
    input  logic                R_Signed,
    input  logic [31:0]         ALUResult,
    input  logic [31:0]         Reg_Data2,
    input  logic [2:0]          BranchSel,
    input  logic                Zero,
    input  logic [31:0]         PC_Plus_Branch,
    input  logic [31:0]         PC_Plus4,
    input  logic [27:0]         j_sll_two,
    output logic [31:0]         R_Data,
    output logic                Resp_Valid,
    output logic [31:0]         PCNew,
    output logic [1:0]          PCSrc,
    output logic                Stall,
    output logic                Misalign
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [3:0] CNT_INIT =
        (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [31:0]       mem [2**ADDR_W];

    logic              q_rd, q_wr, q_sg;
    logic [1:0]        q_rw, q_ww, q_src;
    logic [ADDR_W+1:0] q_addr;
    logic [31:0]       q_wdata, q_pc;

    logic              in_idle, accept, mem_op, enter_done;
    logic              cur_rd, cur_wr, cur_sg;
    logic [1:0]        cur_rw, cur_ww, cur_src, acc_w, lane;
    logic [ADDR_W+1:0] cur_addr;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       cur_wdata, cur_pc;
    logic              is_half, is_byte, trap, we;
    logic [3:0]        mask;
    logic [31:0]       wd, rword, ld_val;
    logic [15:0]       hsel;
    logic [7:0]        bsel;
    logic [31:0]       br_pc;
    logic [1:0]        br_src;

    assign in_idle    = (state == IDLE);
    assign Req_Ready  = in_idle;
    assign Resp_Valid = (state == DONE);
    assign Stall      = !in_idle;
    assign accept     = Req_Valid & in_idle;
    assign mem_op     = R_Enable | W_Enable;

    assign enter_done =
        (accept && !(mem_op && (MEM_LAT > 1))) ||
        (state == BUSY && cnt == 4'd0);

    // Live inputs on a direct accept, captured copy while busy
    assign cur_rd    = in_idle ? R_Enable : q_rd;
    assign cur_wr    = in_idle ? W_Enable : q_wr;
    assign cur_sg    = in_idle ? R_Signed : q_sg;
    assign cur_rw    = in_idle ? R_Width : q_rw;
    assign cur_ww    = in_idle ? W_Width : q_ww;
    assign cur_addr  = in_idle ? ALUResult[ADDR_W+1:0] : q_addr;
    assign cur_wdata = in_idle ? Reg_Data2 : q_wdata;
    assign cur_pc    = in_idle ? br_pc : q_pc;
    assign cur_src   = in_idle ? br_src : q_src;

    assign acc_w   = cur_wr ? cur_ww : cur_rw;
    assign is_half = (acc_w == 2'b01);
    assign is_byte = (acc_w == 2'b10);
    assign idx     = cur_addr[ADDR_W+1:2];

    // Byte lane of the access; misaligned low bits dropped
    always_comb begin
        lane = 2'b00;
        if (is_byte)
            lane = cur_addr[1:0];
        else if (is_half)
            lane = {cur_addr[1], 1'b0};
    end

`ifdef MISALIGN_TRAP_EN
    logic misal;
    logic mis_q;
    assign misal = is_half ? cur_addr[0] :
                   is_byte ? 1'b0 :
                   (cur_addr[1:0] != 2'b00);
    assign trap     = misal & (cur_rd | cur_wr);
    assign Misalign = mis_q;

    // Misalign flag lives for exactly the DONE cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            mis_q <= 1'b0;
        else
            mis_q <= enter_done & trap;
    end
`else
    assign trap     = 1'b0;
    assign Misalign = 1'b0;
`endif

    // Redirect decode from the live branch inputs
    always_comb begin
        br_pc  = PC_Plus4;
        br_src = 2'b00;
        unique case (1'b1)
            (BranchSel == 3'b001 && Zero),
            (BranchSel == 3'b010 && !Zero): begin
                br_pc  = PC_Plus_Branch;
                br_src = 2'b01;
            end
            (BranchSel == 3'b011): begin
                br_pc  = {PC_Plus4[31:28], j_sll_two};
                br_src = 2'b10;
            end
            (BranchSel == 3'b100): begin
                br_pc  = ALUResult;
                br_src = 2'b11;
            end
            default: ;
        endcase
    end

    // Store lane mask and lane-replicated write data
    always_comb begin
        mask = 4'b1111;
        wd   = cur_wdata;
        if (is_byte) begin
            mask = 4'b0001 << lane;
            wd   = {4{cur_wdata[7:0]}};
        end else if (is_half) begin
            mask = lane[1] ? 4'b1100 : 4'b0011;
            wd   = {2{cur_wdata[15:0]}};
        end
    end

    assign we = enter_done & cur_wr & !trap & Reset;

    // Memory array, never cleared by reset
    always_ff @(posedge Clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i])
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign rword = mem[idx];
    assign hsel  = lane[1] ? rword[31:16] : rword[15:0];
    assign bsel  = rword[8*lane +: 8];

    // Sub-word extract with sign or zero extension
    always_comb begin
        ld_val = rword;
        if (is_byte)
            ld_val = {{24{cur_sg & bsel[7]}}, bsel};
        else if (is_half)
            ld_val = {{16{cur_sg & hsel[15]}}, hsel};
    end

    // Request capture on accept
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_rd    <= 1'b0;
            q_wr    <= 1'b0;
            q_sg    <= 1'b0;
            q_rw    <= 2'b00;
            q_ww    <= 2'b00;
            q_addr  <= '0;
            q_wdata <= '0;
            q_pc    <= '0;
            q_src   <= 2'b00;
        end else if (accept) begin
            q_rd    <= R_Enable;
            q_wr    <= W_Enable;
            q_sg    <= R_Signed;
            q_rw    <= R_Width;
            q_ww    <= W_Width;
            q_addr  <= ALUResult[ADDR_W+1:0];
            q_wdata <= Reg_Data2;
            q_pc    <= br_pc;
            q_src   <= br_src;
        end
    end

    // Control FSM with latency countdown
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (mem_op && (MEM_LAT > 1)) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end else begin
                        state <= DONE;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0)
                        state <= DONE;
                    else
                        cnt <= cnt - 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result registers committed on entry to DONE
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            R_Data <= '0;
            PCNew  <= '0;
            PCSrc  <= 2'b00;
        end else if (enter_done) begin
            PCNew <= cur_pc;
            PCSrc <= cur_src;
            if (trap)
                R_Data <= '0;
            else if (cur_rd && !cur_wr)
                R_Data <= ld_val;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit (MEM_LAT=2, ADDR_W=10).
// Expected values are hand-computed per directed vector.
module tb_memory_access_unit;

    localparam int LAT = 2;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        R_Enable = 1'b0;
    logic        W_Enable = 1'b0;
    logic [1:0]  R_Width = 2'b00;
    logic [1:0]  W_Width = 2'b00;
    logic        R_Signed = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] Reg_Data2 = '0;
    logic [2:0]  BranchSel = 3'b000;
    logic        Zero = 1'b0;
    logic [31:0] PC_Plus_Branch = '0;
    logic [31:0] PC_Plus4 = '0;
    logic [27:0] j_sll_two = '0;
    logic [31:0] R_Data;
    logic        Resp_Valid;
    logic [31:0] PCNew;
    logic [1:0]  PCSrc;
    logic        Stall;
    logic        Misalign;

    memory_access_unit #(.ADDR_W(10), .MEM_LAT(LAT)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .R_Enable(R_Enable), .W_Enable(W_Enable),
        .R_Width(R_Width), .W_Width(W_Width),
        .R_Signed(R_Signed), .ALUResult(ALUResult),
        .Reg_Data2(Reg_Data2), .BranchSel(BranchSel),
        .Zero(Zero), .PC_Plus_Branch(PC_Plus_Branch),
        .PC_Plus4(PC_Plus4), .j_sll_two(j_sll_two),
        .R_Data(R_Data), .Resp_Valid(Resp_Valid),
        .PCNew(PCNew), .PCSrc(PCSrc),
        .Stall(Stall), .Misalign(Misalign)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] r;
        logic [31:0] pc;
        logic [1:0]  src;
        logic        mis;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          run = 0;
    int          last_wait = 0;
    logic [31:0] exp_r = '0;
    logic [31:0] pc4 = 32'h0040_0000;
    bit          keep = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    always @(posedge Clock) cyc++;

    // Monitor: pop and compare on every response
    always @(negedge Clock) begin
        exp_t e;
        if (Stall) run++;
        else run = 0;
        if (Resp_Valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("r_data", R_Data, e.r);
                chk("pc_new", PCNew, e.pc);
                chk("pc_src", 32'(PCSrc), 32'(e.src));
                chk("misalign", 32'(Misalign), 32'(e.mis));
                chk("latency", cyc - e.acc, e.lat);
                chk("stall_len", run, e.lat);
                chk("ready_in_done", 32'(Req_Ready), 32'd0);
            end
        end
    end

    task automatic issue(
        input logic rd, input logic wr,
        input logic [1:0] rw, input logic [1:0] ww,
        input logic sg, input logic [31:0] addr,
        input logic [31:0] wdat, input logic [2:0] bs,
        input logic z, input logic [31:0] pcb,
        input logic [31:0] p4, input logic [27:0] jt,
        input logic [31:0] rexp, input logic [31:0] pcexp,
        input logic [1:0] srcexp, input logic misexp,
        input bit push);
        int n;
        exp_t e;
        @(negedge Clock);
        Req_Valid = 1'b1;
        R_Enable = rd; W_Enable = wr;
        R_Width = rw; W_Width = ww; R_Signed = sg;
        ALUResult = addr; Reg_Data2 = wdat;
        BranchSel = bs; Zero = z;
        PC_Plus_Branch = pcb; PC_Plus4 = p4;
        j_sll_two = jt;
        n = 0;
        while (!Req_Ready && n < 50) begin
            @(negedge Clock);
            n++;
        end
        last_wait = n;
        if (!Req_Ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            return;
        end
        e.r = rexp; e.pc = pcexp; e.src = srcexp;
        e.mis = misexp; e.acc = cyc;
        e.lat = (rd | wr) ? LAT : 1;
        if (push) q.push_back(e);
        @(posedge Clock);
    endtask

    task automatic idle();
        @(negedge Clock);
        Req_Valid = 1'b0;
        R_Enable = 1'b0;
        W_Enable = 1'b0;
    endtask

    task automatic st(input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic mis);
        pc4 += 4;
        if (mis) exp_r = '0;
        issue(1'b0, 1'b1, 2'b00, w, 1'b0, a, d, 3'b000, 1'b0,
              32'h0, pc4, 28'h0, exp_r, pc4, 2'b00, mis, 1'b1);
        if (!keep) idle();
    endtask

    task automatic ld(input logic [1:0] w, input logic sg,
                      input logic [31:0] a, input logic [31:0] v,
                      input logic mis);
        pc4 += 4;
        exp_r = mis ? 32'h0 : v;
        issue(1'b1, 1'b0, w, 2'b00, sg, a, 32'h0, 3'b000, 1'b0,
              32'h0, pc4, 28'h0, exp_r, pc4, 2'b00, mis, 1'b1);
        if (!keep) idle();
    endtask

    task automatic br(input logic [2:0] bs, input logic z,
                      input logic [31:0] pcb, input logic [31:0] p4,
                      input logic [27:0] jt, input logic [31:0] alu,
                      input logic [31:0] pcexp,
                      input logic [1:0] srcexp);
        issue(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, alu, 32'h0, bs, z,
              pcb, p4, jt, exp_r, pcexp, srcexp, 1'b0, 1'b1);
        idle();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(Req_Ready), 32'd1);
        chk({tag, "_resp"}, 32'(Resp_Valid), 32'd0);
        chk({tag, "_stall"}, 32'(Stall), 32'd0);
        chk({tag, "_rdata"}, R_Data, 32'h0);
        chk({tag, "_pcnew"}, PCNew, 32'h0);
        chk({tag, "_pcsrc"}, 32'(PCSrc), 32'd0);
        chk({tag, "_mis"}, 32'(Misalign), 32'd0);
    endtask

    initial begin
        logic [31:0] w20;
        int n;
        repeat (3) @(negedge Clock);
        chk_reset_outs("rst");
        Reset = 1'b1;

        st(2'b00, 32'h10, 32'hDEAD_BEEF, 1'b0);
        ld(2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        st(2'b10, 32'h13, 32'h1234_5680, 1'b0);
        ld(2'b10, 1'b1, 32'h13, 32'hFFFF_FF80, 1'b0);
        ld(2'b10, 1'b0, 32'h13, 32'h0000_0080, 1'b0);
        ld(2'b00, 1'b0, 32'h10, 32'h80AD_BEEF, 1'b0);

        st(2'b00, 32'h14, 32'h0000_1111, 1'b0);
        st(2'b01, 32'h16, 32'hFFFF_A5A5, 1'b0);
        ld(2'b01, 1'b1, 32'h16, 32'hFFFF_A5A5, 1'b0);
        ld(2'b01, 1'b0, 32'h16, 32'h0000_A5A5, 1'b0);
        ld(2'b00, 1'b0, 32'h14, 32'hA5A5_1111, 1'b0);

        br(3'b001, 1'b1, 32'h0040_0040, 32'h0040_0008,
           28'h0, 32'h0, 32'h0040_0040, 2'b01);
        br(3'b001, 1'b0, 32'h0040_0040, 32'h0040_000C,
           28'h0, 32'h0, 32'h0040_000C, 2'b00);
        br(3'b010, 1'b0, 32'h0040_0080, 32'h0040_0010,
           28'h0, 32'h0, 32'h0040_0080, 2'b01);
        br(3'b010, 1'b1, 32'h0040_0080, 32'h0040_0014,
           28'h0, 32'h0, 32'h0040_0014, 2'b00);
        br(3'b011, 1'b0, 32'h0, 32'h1040_0010,
           28'h0ABCDE0, 32'h0, 32'h10AB_CDE0, 2'b10);
        br(3'b100, 1'b0, 32'h0, 32'h0040_0018,
           28'h0, 32'h0040_1234, 32'h0040_1234, 2'b11);
        br(3'b111, 1'b1, 32'h0040_0100, 32'h0040_001C,
           28'h0, 32'h0, 32'h0040_001C, 2'b00);

        pc4 += 4;
        issue(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 32'h18,
              32'h5566_7788, 3'b000, 1'b0, 32'h0, pc4, 28'h0,
              exp_r, pc4, 2'b00, 1'b0, 1'b1);
        idle();
        ld(2'b00, 1'b0, 32'h18, 32'h5566_7788, 1'b0);

        st(2'b00, 32'h101C, 32'h0BAD_F00D, 1'b0);
        ld(2'b00, 1'b0, 32'h1C, 32'h0BAD_F00D, 1'b0);

        keep = 1'b1;
        ld(2'b00, 1'b0, 32'h10, 32'h80AD_BEEF, 1'b0);
        ld(2'b00, 1'b0, 32'h14, 32'hA5A5_1111, 1'b0);
        keep = 1'b0;
        chk("b2b_wait", last_wait, LAT);
        idle();

        st(2'b00, 32'h20, 32'h1111_1111, 1'b0);
        st(2'b00, 32'h22, 32'h1234_5678, TRAP);
        w20 = TRAP ? 32'h1111_1111 : 32'h1234_5678;
        ld(2'b00, 1'b0, 32'h20, w20, 1'b0);
        ld(2'b01, 1'b1, 32'h13, 32'hFFFF_80AD, TRAP);

        pc4 += 4;
        issue(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h20,
              32'hCAFE_F00D, 3'b000, 1'b0, 32'h0, pc4, 28'h0,
              exp_r, pc4, 2'b00, 1'b0, 1'b0);
        @(negedge Clock);
        Req_Valid = 1'b0;
        W_Enable = 1'b0;
        Reset = 1'b0;
        #1;
        chk_reset_outs("abort");
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        exp_r = '0;
        ld(2'b00, 1'b0, 32'h20, w20, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        chk("pending_resp", q.size(), 32'd0);
        repeat (2) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set memory depth to 2^ADDR_W 32-bit words.
REQ-002 Parameter MEM_LAT, default 2, legal range 1..8, SHALL set memory-op latency in cycles.
REQ-003 Clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  SHALL be asynchronous, active-low.
REQ-005 Req_Valid  in  1  SHALL mean a MEM-stage request is presented.
REQ-006 Req_Ready  out  1  SHALL mean a request can be accepted this cycle.
REQ-007 R_Enable, W_Enable  in  1 each  SHALL mean load and store.
REQ-008 R_Width, W_Width  in  2 each  SHALL encode 00 word, 01 halfword, 10 byte; 11 treated as word.
REQ-009 R_Signed  in  1  SHALL select sign-extension (1) or zero-extension (0) of sub-word loads.
REQ-010 ALUResult  in  32  SHALL be the byte address and the jr target.
REQ-011 Reg_Data2  in  32  SHALL be store data, taken from the low-order bytes.
REQ-012 BranchSel  in  3  SHALL encode 000 none, 001 beq, 010 bne, 011 j/jal, 100 jr; others = none.
REQ-013 Zero  in  1, PC_Plus_Branch  in  32, PC_Plus4  in  32, j_sll_two  in  28  SHALL be branch inputs.
REQ-014 R_Data  out  32  SHALL be extended load data.
REQ-015 Resp_Valid  out  1  SHALL pulse one cycle when a request completes.
REQ-016 PCNew  out  32, PCSrc  out  2  SHALL be the registered redirect target; PCSrc 00 sequential, 01 branch, 10 jump, 11 jr.
REQ-017 Stall  out  1  SHALL be high while a request is in flight.
REQ-018 Misalign  out  1  SHALL flag a misaligned access (see Configuration).

Function
REQ-019 Accept SHALL occur on the edge where Req_Valid & Req_Ready; all inputs captured then.
REQ-020 FSM SHALL have states IDLE, BUSY, DONE; Req_Ready=1 only in IDLE.
REQ-021 IDLE->BUSY on accept of a load/store with MEM_LAT>1; IDLE->DONE on accept otherwise.
REQ-022 BUSY SHALL count down MEM_LAT-1 cycles, then enter DONE; DONE->IDLE unconditionally.
REQ-023 Resp_Valid SHALL be 1 only in DONE: accept edge k -> response in cycle k+MEM_LAT (memory op) or k+1 (none).
REQ-024 Stall SHALL be 1 in BUSY and DONE; Req_Valid there SHALL be ignored.
REQ-025 Word index SHALL be ALUResult[ADDR_W+1:2]; byte lane ALUResult[1:0], little-endian.
REQ-026 Store SHALL write only selected lanes (byte: 1 lane; half: lanes {a1,0},{a1,1}) on the edge entering DONE.
REQ-027 Load SHALL update R_Data on entering DONE; R_Data SHALL hold until the next load completes.
REQ-028 R_Enable and W_Enable both set SHALL perform the store only; R_Data holds.
REQ-029 Branch: beq&Zero or bne&!Zero -> 01, PC_Plus_Branch; j/jal -> 10, {PC_Plus4[31:28], j_sll_two}; jr -> 11, ALUResult; else 00, PC_Plus4.
REQ-030 PCNew/PCSrc SHALL update on entering DONE and hold otherwise.
REQ-031 Address beyond 2^ADDR_W words SHALL wrap (upper bits ignored).

Reset
REQ-032 Reset low SHALL force IDLE, counter 0, R_Data=0, PCNew=0, PCSrc=00, Resp_Valid=0, Stall=0, Misalign=0.
REQ-033 Reset mid-request SHALL abort it with no write; memory contents SHALL NOT be cleared.

Configuration
REQ-034 With MISALIGN_TRAP_EN defined: word with addr[1:0]!=0 or half with addr[0]!=0 SHALL suppress the store, set R_Data=0, and assert Misalign with Resp_Valid.
REQ-035 Without MISALIGN_TRAP_EN: offending low address bits SHALL be forced to 0 and Misalign tied 0.

Verification
REQ-036 MEM_LAT=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> Resp_Valid at k+2, R_Data=0xDEADBEEF.
REQ-037 Store byte 0x80 @0x13, load byte @0x13 R_Signed=1 -> 0xFFFFFF80; R_Signed=0 -> 0x00000080; word @0x10 = 0x80ADBEEF.
REQ-038 beq, Zero=1, PC_Plus_Branch=0x00400040, no memory op -> Resp_Valid at k+1, PCSrc=01, PCNew=0x00400040; Zero=0 -> 00, PC_Plus4.
REQ-039 Req_Valid held high during BUSY -> second request accepted only after DONE; Stall high for exactly MEM_LAT cycles.
REQ-040 Reset low one cycle after accepting a store @0x20 -> word @0x20 unchanged, all outputs at reset values.
REQ-041 MISALIGN_TRAP_EN defined: store word @0x22 -> Misalign=1 with Resp_Valid, memory unchanged.
